// File: rtl/num_to_tx.sv
// Latches a binary value on start and streams it to the UART TX FIFO as uppercase ASCII hex, MS digit first.
// Define APPEND_CRLF_EN to follow the digits with a CR/LF terminator.
module num_to_tx #(
  parameter int NDIGITS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   tx_full,
  output logic [7:0]             tx_data,
  output logic                   tx_wr,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP,
`ifdef APPEND_CRLF_EN
    SEND_CR,
    GAP_CR,
    SEND_LF,
    GAP_LF,
`endif
    FIN
  } state_e;

  state_e               state_q, state_d;
  logic [4*NDIGITS-1:0] valueLat_q, valueLat_d;
  logic [CW-1:0]        digitCnt_q, digitCnt_d;
  logic [7:0]           txData_q, txData_d;
  logic                 txWr_q, txWr_d;
  logic [3:0]           curNibble;

  function automatic logic [7:0] toAscii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    curNibble = 4'h0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (digitCnt_q == CW'(i)) curNibble = valueLat_q[4*i +: 4];
    end
  end

  // Each write state stalls on tx_full; each write is followed by a GAP so the full flag can settle.
  always_comb begin
    state_d    = state_q;
    valueLat_d = valueLat_q;
    digitCnt_d = digitCnt_q;
    txData_d   = txData_q;
    txWr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          valueLat_d = value;
          digitCnt_d = CW'(NDIGITS - 1);
          state_d    = SEND;
        end
      end
      SEND: begin
        if (!tx_full) begin
          txData_d = toAscii(curNibble);
          txWr_d   = 1'b1;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (digitCnt_q != '0) begin
          digitCnt_d = digitCnt_q - CW'(1);
          state_d    = SEND;
        end else begin
`ifdef APPEND_CRLF_EN
          state_d = SEND_CR;
`else
          state_d = FIN;
`endif
        end
      end
`ifdef APPEND_CRLF_EN
      SEND_CR: begin
        if (!tx_full) begin
          txData_d = 8'h0D;
          txWr_d   = 1'b1;
          state_d  = GAP_CR;
        end
      end
      GAP_CR: state_d = SEND_LF;
      SEND_LF: begin
        if (!tx_full) begin
          txData_d = 8'h0A;
          txWr_d   = 1'b1;
          state_d  = GAP_LF;
        end
      end
      GAP_LF: state_d = FIN;
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valueLat_q <= '0;
      digitCnt_q <= '0;
      txData_q   <= 8'h00;
      txWr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      valueLat_q <= valueLat_d;
      digitCnt_q <= digitCnt_d;
      txData_q   <= txData_d;
      txWr_q     <= txWr_d;
    end
  end

  assign tx_data = txData_q;
  assign tx_wr   = txWr_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FIN);

endmodule
